instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage for the single-issue RV32I core: owns the program counter, issues one word request at a time to instruction memory, and presents the fetched `instruction_code`, with its `pc` and `pc_plus4`, to the control unit and datapath. It consumes the control unit's `PCSrc` select and the datapath's target addresses to choose the next PC. It traps on misaligned control-flow targets (no C extension).

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; must be word aligned.
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `PCSrc`  in  2  next-PC select: 0 PC+4, 1 branch target, 2 JAL target, 3 JALR target.
- `branch_target`  in  32  PC+imm for a taken branch.
- `jal_target`  in  32  PC+imm for JAL.
- `jalr_target`  in  32  rs1+imm for JALR (raw; bit 0 not yet cleared).
- `decode_ready`  in  1  downstream consumes the held instruction this cycle; `PCSrc` and targets are valid.
- `imem_req_valid`  out  1  fetch request.
- `imem_req_addr`  out  32  word address of the request.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_resp_valid`  in  1  read data valid.
- `imem_resp_data`  in  32  fetched word.
- `instruction_code`  out  32  held instruction.
- `instr_valid`  out  1  `instruction_code`, `pc`, and `pc_plus4` are valid.
- `pc`  out  32  address of the held instruction.
- `pc_plus4`  out  32  `pc`+4, mod 2^32.
- `misaligned_target`  out  1  sticky trap flag.
- `fetch_count`  out  32  instructions consumed; wraps to 0 after 32'hFFFF_FFFF.

## Operation
- FSM states:
  - S_BOOT: entered on reset; goes to S_REQ on the next cycle.
  - S_REQ: `imem_req_valid`=1 and `imem_req_addr`=`pc`. On `imem_req_ready`=1, go to S_WAIT.
  - S_WAIT: `imem_resp_valid` is ignored in the acceptance cycle. On `imem_resp_valid`=1, register `imem_resp_data` into `instruction_code` and go to S_HOLD.
  - S_HOLD: `instr_valid`=1. While `decode_ready`=0, everything holds. On `decode_ready`=1, compute `next_pc`, increment `fetch_count`, and then either trap or move on:
    - if `next_pc`[1:0]≠0, set `misaligned_target`=1 and go to S_TRAP; `pc` and `instruction_code` are unchanged;
    - otherwise load `pc`←`next_pc` and go to S_REQ.
  - S_TRAP: `instr_valid`=0 and `imem_req_valid`=0. Only `rst` exits this state.
- `next_pc` by `PCSrc`:
  - 0: `pc_plus4`
  - 1: `branch_target`
  - 2: `jal_target`
  - 3: {`jalr_target`[31:1], 1'b0}
- Alignment check is applied to `next_pc` after the JALR bit-0 clear. A PC+4 path can never trap.
- PC arithmetic is 32-bit and wraps: `pc`=32'hFFFF_FFFC gives `pc_plus4`=0.
- `PCSrc`, targets, and `decode_ready` are sampled only in S_HOLD; they are don't-care elsewhere.
- `imem_resp_valid` outside S_WAIT is ignored.
- At most one request is outstanding. Instruction memory is reset by the same `rst`, so no stale response arrives after reset.
- Reset values:
  - `pc`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4
  - `instruction_code`=32'h0000_0013 (NOP)
  - `instr_valid`=0, `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`
  - `misaligned_target`=0, `fetch_count`=0
- Reset mid-operation, in any state including S_WAIT or S_TRAP, returns to S_BOOT with the reset values on the next edge. An in-flight response is discarded.

## Timing
- All outputs are registered except `imem_req_valid`, which is decoded from the state register. `imem_req_addr` equals `pc`.
- First request: `rst` deasserts at edge 0; S_REQ is entered at edge 1, with `imem_req_valid`=1 during cycle 1.
- Zero-wait memory (ready=1, response one cycle after acceptance): accept in cycle n, response in cycle n+1, `instr_valid`=1 in cycle n+2.
- Throughput is one instruction per 3 cycles with zero-wait memory and `decode_ready` high. Each stall cycle of `imem_req_ready`, `imem_resp_valid`, or `decode_ready` adds one cycle.
- `pc` and `fetch_count` update on the edge ending the `decode_ready`=1 cycle in S_HOLD. `instr_valid` drops in the following cycle.
- `misaligned_target` rises on that same edge and stays high until `rst`.

## Test plan
- Reset/boot:
  - Stimulus: `RESET_PC`=32'h0000_0100, hold `rst` 3 cycles, then release.
  - Required: all reset values during reset; `imem_req_valid`=1 with `imem_req_addr`=32'h100 exactly one cycle after release.
- Sequential fetch:
  - Stimulus: zero-wait memory, `decode_ready`=1, `PCSrc`=0, 4 instructions.
  - Required: addresses 0x100, 0x104, 0x108, 0x10C, 3 cycles apart; `fetch_count`=4; `instruction_code` matches memory.
- Control flow:
  - Stimulus 1: `PCSrc`=1 with `branch_target`=32'h200. Required: next request at 0x200.
  - Stimulus 2: `PCSrc`=3 with `jalr_target`=32'h301. Required: next request at 0x300 and no trap.
- Stalls:
  - Stimulus: `imem_req_ready` low 2 cycles, response delayed 3 cycles, `decode_ready` low 4 cycles.
  - Required: address and data held stable throughout; `instr_valid` steady; `fetch_count` increments exactly once.
- Trap:
  - Stimulus: `PCSrc`=2 with `jal_target`=32'h0000_0402.
  - Required: `misaligned_target`=1, `pc` unchanged, no further requests for 20 cycles; after `rst`, fetch resumes at `RESET_PC`.
- Reset in S_WAIT and wrap-around:
  - Stimulus 1: assert `rst` during S_WAIT, then drive a late `imem_resp_valid`. Required: the late response is ignored.
  - Stimulus 2: `pc`=32'hFFFF_FFFC with `PCSrc`=0. Required: next request at 32'h0000_0000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem word request at a
// time, holds the fetched instruction for decode and selects the next PC.
// Misaligned control-flow targets park the unit in a sticky trap state.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] branch_target,
  input  logic [31:0] jal_target,
  input  logic [31:0] jalr_target,
  input  logic        decode_ready,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] instruction_code,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misaligned_target,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD, S_TRAP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] next_pc;

  // Next-PC mux; JALR clears bit 0 before the alignment check sees it.
  always_comb begin
    next_pc = pc_plus4_q;
    case (PCSrc)
      2'd0:    next_pc = pc_plus4_q;
      2'd1:    next_pc = branch_target;
      2'd2:    next_pc = jal_target;
      default: next_pc = jalr_target & 32'hFFFF_FFFE;
    endcase
  end

  // Fetch FSM next-state and registered-output updates.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_plus4_d    = pc_plus4_q;
    instr_d       = instr_q;
    misaligned_d  = misaligned_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ:  if (imem_req_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_resp_valid) begin
          instr_d = imem_resp_data;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (decode_ready) begin
          fetch_count_d = fetch_count_q + 32'd1;
          if (next_pc[1:0] != 2'b00) begin
            // PC and instruction stay on the faulting instruction.
            misaligned_d = 1'b1;
            state_d      = S_TRAP;
          end else begin
            pc_d       = next_pc;
            pc_plus4_d = next_pc + 32'd4;
            state_d    = S_REQ;
          end
        end
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_BOOT;
    endcase
    instr_valid_d = (state_d == S_HOLD);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      pc_plus4_q    <= RESET_PC + 32'd4;
      instr_q       <= NOP;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_plus4_q    <= pc_plus4_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      misaligned_q  <= misaligned_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_req_valid    = (state_q == S_REQ);
  assign imem_req_addr     = pc_q;
  assign instruction_code  = instr_q;
  assign instr_valid       = instr_valid_q;
  assign pc                = pc_q;
  assign pc_plus4          = pc_plus4_q;
  assign misaligned_target = misaligned_q;
  assign fetch_count       = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: scripted imem responder, a transaction-level
// model checked every cycle, and directed literal checks per scenario.
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  PCSrc = 2'd0;
  logic [31:0] branch_target = '0, jal_target = '0, jalr_target = '0;
  logic        decode_ready = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic [31:0] instruction_code, pc, pc_plus4, fetch_count;
  logic        instr_valid, misaligned_target;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .PCSrc(PCSrc), .branch_target(branch_target),
    .jal_target(jal_target), .jalr_target(jalr_target), .decode_ready(decode_ready),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .instruction_code(instruction_code),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .misaligned_target(misaligned_target), .fetch_count(fetch_count)
  );

  int n_chk = 0, n_fail = 0, cyc_n = 0;
  bit chk_on = 0;

  // memory responder state
  bit          pend = 0, accepted = 0, resp_given = 0, inject_late = 0;
  logic [31:0] pend_addr = '0;
  int          stall_req = 0, stall_resp = 0;
  logic [31:0] log_addr[$];
  int          log_cyc[$];

  // model state
  logic [31:0] e_pc = RPC, e_cnt = 0;
  bit          e_trap = 0, e_valid = 0, e_req = 0, e_boot = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic mem_step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    accepted = 0; resp_given = 0;
    if (rst) begin
      pend = 0;
    end else if (inject_late) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hDEAD_BEEF;
      inject_late = 0;
    end else if (pend) begin
      if (stall_resp > 0) stall_resp--;
      else begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(pend_addr);
        pend = 0; resp_given = 1;
      end
    end else if (imem_req_valid) begin
      if (stall_req > 0) stall_req--;
      else begin
        imem_req_ready = 1'b1;
        pend = 1; pend_addr = imem_req_addr; accepted = 1;
        log_addr.push_back(imem_req_addr);
        log_cyc.push_back(cyc_n);
      end
    end
  endtask

  // Compare DUT against the model, then advance the model past this edge.
  task automatic model_step();
    logic [31:0] nxt;
    if (chk_on) begin
      chk("fetch_count", fetch_count, e_cnt);
      chk("misaligned_target", {31'b0, misaligned_target}, {31'b0, e_trap});
      chk("pc", pc, e_pc);
      chk("pc_plus4", pc_plus4, e_pc + 32'd4);
      chk("imem_req_addr", imem_req_addr, e_pc);
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, e_valid});
      chk("imem_req_valid", {31'b0, imem_req_valid}, {31'b0, e_req});
      if (e_valid) chk("instruction_code", instruction_code, mem_word(e_pc));
    end
    if (rst) begin
      e_pc = RPC; e_cnt = 0; e_trap = 0; e_valid = 0; e_req = 0; e_boot = 1;
    end else begin
      if (e_boot) begin e_boot = 0; e_req = 1; end
      else if (accepted) e_req = 0;
      if (resp_given) e_valid = 1;
      else if (e_valid && decode_ready) begin
        e_cnt = e_cnt + 1;
        e_valid = 0;
        case (PCSrc)
          2'd0:    nxt = e_pc + 32'd4;
          2'd1:    nxt = branch_target;
          2'd2:    nxt = jal_target;
          default: nxt = jalr_target - (jalr_target % 2);
        endcase
        if (nxt % 4 != 0) e_trap = 1;
        else begin e_pc = nxt; e_req = 1; end
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    mem_step();
    #1;
    model_step();
    @(posedge clk);
    cyc_n++;
    #1;
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!instr_valid && k < 40) begin cyc(); k++; end
    chk("wait_instr_valid", {31'b0, instr_valid}, 32'd1);
  endtask

  task automatic consume(input logic [1:0] src, input logic [31:0] tgt);
    wait_valid();
    PCSrc = src; branch_target = tgt; jal_target = tgt; jalr_target = tgt;
    decode_ready = 1'b1;
    cyc();
    decode_ready = 1'b0;
    PCSrc = 2'd0;
  endtask

  initial begin
    int c0, cc, nlog, k;
    // Reset held 3 cycles
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_on = 1;
      chk("rst_pc", pc, 32'h100);
      chk("rst_pc_plus4", pc_plus4, 32'h104);
      chk("rst_instr", instruction_code, 32'h13);
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("rst_req_addr", imem_req_addr, 32'h100);
      chk("rst_mis", {31'b0, misaligned_target}, 32'd0);
      chk("rst_cnt", fetch_count, 32'd0);
    end
    rst = 1'b0;
    decode_ready = 1'b1;
    c0 = cyc_n;
    chk("boot_req_valid", {31'b0, imem_req_valid}, 32'd0);
    cyc();
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h100);

    // Sequential fetch of 4 instructions
    k = 0;
    while (fetch_count != 32'd4 && k < 40) begin cyc(); k++; end
    decode_ready = 1'b0;
    chk("seq_count", fetch_count, 32'd4);
    if (log_addr.size() >= 4) begin
      chk("seq_addr0", log_addr[0], 32'h100);
      chk("seq_addr1", log_addr[1], 32'h104);
      chk("seq_addr2", log_addr[2], 32'h108);
      chk("seq_addr3", log_addr[3], 32'h10C);
      chk("seq_first_cyc", log_cyc[0], c0 + 1);
      for (int i = 1; i < 4; i++) chk("seq_spacing", log_cyc[i] - log_cyc[i-1], 32'd3);
    end else chk("seq_log_size", log_addr.size(), 32'd4);

    // Branch then JALR with odd target
    wait_valid();
    chk("hold_pc", pc, 32'h110);
    consume(2'd1, 32'h200);
    chk("br_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("br_req_addr", imem_req_addr, 32'h200);
    chk("br_cnt", fetch_count, 32'd5);
    consume(2'd3, 32'h301);
    chk("jalr_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("jalr_req_addr", imem_req_addr, 32'h300);
    chk("jalr_no_trap", {31'b0, misaligned_target}, 32'd0);

    // Stalls on request, response and decode
    wait_valid();
    stall_req = 2; stall_resp = 3;
    consume(2'd0, 32'h0);
    cc = cyc_n;
    wait_valid();
    chk("stall_acc_addr", log_addr[$], 32'h304);
    chk("stall_acc_cyc", log_cyc[$], cc + 2);
    chk("stall_valid_cyc", cyc_n, cc + 7);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("dstall_valid", {31'b0, instr_valid}, 32'd1);
      chk("dstall_pc", pc, 32'h304);
      chk("dstall_instr", instruction_code, mem_word(32'h304));
      chk("dstall_cnt", fetch_count, 32'd7);
    end
    consume(2'd0, 32'h0);
    chk("stall_cnt_once", fetch_count, 32'd8);
    cyc(); cyc();
    chk("stall_cnt_hold", fetch_count, 32'd8);

    // Misaligned JAL trap
    consume(2'd2, 32'h0000_0402);
    chk("trap_flag", {31'b0, misaligned_target}, 32'd1);
    chk("trap_pc", pc, 32'h308);
    chk("trap_cnt", fetch_count, 32'd9);
    chk("trap_valid", {31'b0, instr_valid}, 32'd0);
    nlog = log_addr.size();
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("trap_no_req", {31'b0, imem_req_valid}, 32'd0);
    end
    chk("trap_log", nlog, log_addr.size());
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("trap_rst_pc", pc, 32'h100);
    chk("trap_rst_flag", {31'b0, misaligned_target}, 32'd0);
    chk("trap_rst_cnt", fetch_count, 32'd0);

    // Reset during S_WAIT, then a late response
    stall_resp = 5;
    nlog = log_addr.size();
    k = 0;
    while (log_addr.size() == nlog && k < 20) begin cyc(); k++; end
    chk("resume_addr", log_addr[$], 32'h100);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    stall_resp = 0;
    inject_late = 1;
    cyc();
    chk("late_valid", {31'b0, instr_valid}, 32'd0);
    chk("late_instr", instruction_code, 32'h13);
    wait_valid();
    chk("late_fetch_pc", pc, 32'h100);
    chk("late_fetch_instr", instruction_code, mem_word(32'h100));

    // PC wrap-around
    consume(2'd2, 32'hFFFF_FFFC);
    wait_valid();
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc_plus4, 32'h0);
    consume(2'd0, 32'h0);
    chk("wrap_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("wrap_req_addr", imem_req_addr, 32'h0);
    chk("wrap_cnt", fetch_count, 32'd2);
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
